step_dir_gen: RTL and testbench

STEP_DIR_GEN -- requirements
Module: step_dir_gen

---
 rtl/step_dir_gen.sv | 154 +++++++++++++++
 tb/tb_step_dir_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_gen.sv
// Step/direction pulse generator: executes one move command (direction, pulse count, period).
// Define STEP_DIR_GEN_ABORT_EN to add the abort input that ends a command early.
module step_dir_gen #(
    parameter int STEP_WIDTH_CLK = 20,
    parameter int DIR_SETUP_CLK  = 10,
    parameter int CNT_STEPS_W    = 16
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   sclr,
`ifdef STEP_DIR_GEN_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [CNT_STEPS_W-1:0] cmd_steps,
    input  logic [31:0]            cmd_period,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_STEPS_W-1:0] steps_left,
    output logic [2:0]             state_dbg
);

    // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so the command fields are sampled exactly once.

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, FIN} state_t;

    localparam logic [31:0]            WIDTH      = 32'(STEP_WIDTH_CLK);
    localparam logic [31:0]            WIDTH_M1   = 32'(STEP_WIDTH_CLK - 1);
    localparam logic [31:0]            SETUP_M1   = 32'(DIR_SETUP_CLK - 1);
    localparam logic [31:0]            MIN_PERIOD = 32'(2 * STEP_WIDTH_CLK);
    localparam logic [CNT_STEPS_W-1:0] STEP_ONE   = CNT_STEPS_W'(1);

    state_t      state;
    logic [31:0] period;
    logic [31:0] cnt;
    logic        abort_pend;
    logic        abort_req;

`ifdef STEP_DIR_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            period     <= '0;
            cnt        <= '0;
            abort_pend <= 1'b0;
        end else if (sclr) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            period     <= '0;
            cnt        <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    abort_pend <= 1'b0;
                    if (cmd_valid) begin
                        steps_left <= cmd_steps;
                        period     <= (cmd_period > MIN_PERIOD) ? cmd_period : MIN_PERIOD;
                        if (cmd_steps == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (cmd_dir != dir) begin
                            // New direction must settle before the first rising edge.
                            dir   <= cmd_dir;
                            cnt   <= SETUP_M1;
                            state <= SETUP;
                        end else begin
                            step       <= 1'b1;
                            cnt        <= WIDTH_M1;
                            steps_left <= cmd_steps - STEP_ONE;
                            state      <= PULSE;
                        end
                    end
                end
                SETUP: begin
                    if (abort_req) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (cnt == '0) begin
                        step       <= 1'b1;
                        cnt        <= WIDTH_M1;
                        steps_left <= steps_left - STEP_ONE;
                        state      <= PULSE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                PULSE: begin
                    // An abort never shortens the high phase; it is remembered until it ends.
                    if (abort_req) abort_pend <= 1'b1;
                    if (cnt == '0) begin
                        step <= 1'b0;
                        if (abort_req || abort_pend) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= period - WIDTH - 32'd1;
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (cnt == '0) begin
                        if (steps_left != '0) begin
                            step       <= 1'b1;
                            cnt        <= WIDTH_M1;
                            steps_left <= steps_left - STEP_ONE;
                            state      <= PULSE;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: hand-computed command table, random commands against a timing model,
// and reset/clear/abort sequences.
module tb_step_dir_gen;

    localparam int SW = 20;
    localparam int DS = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          sclr = 1'b0;
    logic          abort = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_steps = '0;
    logic [31:0]   cmd_period = '0;
    logic          step;
    logic          dir;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_left;
    logic [2:0]    state_dbg;

    step_dir_gen #(.STEP_WIDTH_CLK(SW), .DIR_SETUP_CLK(DS), .CNT_STEPS_W(CW)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .sclr       (sclr),
`ifdef STEP_DIR_GEN_ABORT_EN
        .abort      (abort),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations of one command, times relative to the accept edge (first cycle after = 1).
    int rise_q[$];
    int width_q[$];
    int done_rel;
    int dir_rel;
    int ready_bad;
    int sl_bad;
    int dir_glitch;
    logic [31:0] exp_q[$];
    logic model_dir;

    typedef struct {
        logic d;
        int   n;
        int   p;
        int   exp_first;
        int   exp_space;
        int   exp_done;
        logic exp_dir;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_cmd(input logic d, input int n, input int p, input int budget, input bit junk);
        int rel;
        int hi_cnt;
        int waitc;
        logic prev_step;
        logic prev_dir;
        rise_q.delete();
        width_q.delete();
        done_rel = -1;
        dir_rel = -1;
        ready_bad = 0;
        sl_bad = 0;
        dir_glitch = 0;
        waitc = 0;
        while (!cmd_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_steps = CW'(n);
        cmd_period = 32'(p);
        prev_step = step;
        prev_dir = dir;
        hi_cnt = 0;
        @(negedge clk);
        rel = 1;
        while (done_rel < 0 && rel <= budget) begin
            if (cmd_ready || !busy) ready_bad++;
            if (step && !prev_step) begin
                rise_q.push_back(rel);
                hi_cnt = 0;
                if (int'(steps_left) != n - rise_q.size()) sl_bad++;
            end
            if (step) hi_cnt++;
            if (!step && prev_step) width_q.push_back(hi_cnt);
            if (dir != prev_dir) begin
                if (dir_rel < 0) dir_rel = rel;
                else dir_glitch++;
                if (step) dir_glitch++;
            end
            if (done) done_rel = rel;
            prev_step = step;
            prev_dir = dir;
            rel++;
            if (done_rel >= 0 || !junk) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_dir = 1'($urandom_range(0, 1));
                cmd_steps = CW'($urandom);
                cmd_period = $urandom;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("ready_after_done", cmd_ready, 1);
        check("done_one_cycle", done, 0);
        check("steps_left_end", steps_left, 0);
    endtask

    // Expected timing from the command rules: first edge after optional direction setup,
    // edges one effective period apart, done one period after the last edge.
    task automatic check_model(input logic d, input int n, input int p, input logic start_dir);
        int pe;
        int off;
        int exp_done;
        int i;
        pe = (p > 2 * SW) ? p : 2 * SW;
        off = (n != 0 && d != start_dir) ? 1 + DS : 1;
        exp_done = (n == 0) ? 1 : off + n * pe;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(32'(off + k * pe));
        check("model_rise_count", rise_q.size(), n);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("model_rise_time", (i < rise_q.size()) ? rise_q[i] : -1, e);
            i++;
        end
        foreach (width_q[k]) check("model_width", width_q[k], SW);
        check("model_done", done_rel, exp_done);
        check("model_dir_change", dir_rel, (n != 0 && d != start_dir) ? 1 : -1);
        check("model_dir_final", dir, (n != 0) ? d : start_dir);
        check("ready_held_off", ready_bad, 0);
        check("steps_left_track", sl_bad, 0);
        check("dir_stable", dir_glitch, 0);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rises;
        int hi;
        int waitc;
        int bad;
        int sl_at_done;
        logic prev;

        vecs[0] = '{1'b0, 3, 100, 1,  100, 301, 1'b0};
        vecs[1] = '{1'b1, 1, 100, 11, 0,   111, 1'b1};
        vecs[2] = '{1'b1, 2, 5,   1,  40,  81,  1'b1};
        vecs[3] = '{1'b0, 0, 50,  0,  0,   1,   1'b1};
        vecs[4] = '{1'b0, 1, 41,  11, 0,   52,  1'b0};
        vecs[5] = '{1'b0, 2, 41,  1,  41,  83,  1'b0};
        vecs[6] = '{1'b1, 2, 39,  11, 40,  91,  1'b1};

        // Asynchronous reset state.
        #1;
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_steps_left", steps_left, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
        model_dir = 1'b0;

        foreach (vecs[v]) begin
            run_cmd(vecs[v].d, vecs[v].n, vecs[v].p, 400, 1'b0);
            check("tbl_rise_count", rise_q.size(), vecs[v].n);
            if (vecs[v].n > 0) check("tbl_first_rise", (rise_q.size() > 0) ? rise_q[0] : -1, vecs[v].exp_first);
            for (int k = 1; k < rise_q.size(); k++) check("tbl_spacing", rise_q[k] - rise_q[k-1], vecs[v].exp_space);
            check("tbl_done", done_rel, vecs[v].exp_done);
            check("tbl_dir", dir, vecs[v].exp_dir);
            check_model(vecs[v].d, vecs[v].n, vecs[v].p, model_dir);
            if (vecs[v].n != 0) model_dir = vecs[v].d;
        end

        for (int r = 0; r < 25; r++) begin
            logic d;
            int n;
            int p;
            int pe;
            bit junk;
            d = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 4);
            p = $urandom_range(1, 120);
            junk = 1'($urandom_range(0, 1));
            pe = (p > 2 * SW) ? p : 2 * SW;
            run_cmd(d, n, p, 1 + DS + n * pe + 20, junk);
            check_model(d, n, p, model_dir);
            if (n != 0) model_dir = d;
        end

        // Synchronous clear 7 cycles into a pulse, with a direction change pending.
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir = ~model_dir;
        cmd_steps = CW'(3);
        cmd_period = 32'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitc = 0;
        while (!step && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("sclr_pulse_started", step, 1);
        for (int k = 1; k < 7; k++) @(negedge clk);
        check("sclr_still_high", step, 1);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        check("sclr_step", step, 0);
        check("sclr_busy", busy, 0);
        check("sclr_steps_left", steps_left, 0);
        check("sclr_dir", dir, 0);
        model_dir = 1'b0;

        // Clear wins over a simultaneous accept.
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_steps = CW'(2);
        cmd_period = 32'd50;
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        cmd_valid = 1'b0;
        check("sclr_prio_busy", busy, 0);
        check("sclr_prio_steps_left", steps_left, 0);
        @(negedge clk);
        check("sclr_prio_step", step, 0);

        // Asynchronous reset in the gap, then no resumption.
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = CW'(3);
        cmd_period = 32'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitc = 0;
        while (!step && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        waitc = 0;
        while (step && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("aclr_in_gap", busy, 1);
        #2;
        aclr_n = 1'b0;
        #1;
        check("aclr_step", step, 0);
        check("aclr_busy", busy, 0);
        check("aclr_steps_left", steps_left, 0);
        check("aclr_dir", dir, 0);
        check("aclr_done", done, 0);
        @(negedge clk);
        aclr_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (step || busy) bad++;
        end
        check("aclr_no_resume", bad, 0);
        model_dir = 1'b0;

`ifdef STEP_DIR_GEN_ABORT_EN
        // Abort during the fourth high phase of a ten-step move.
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_steps = CW'(10);
        cmd_period = 32'd50;
        @(negedge clk);
        cmd_valid = 1'b0;
        rises = 0;
        hi = 0;
        prev = 1'b0;
        sl_at_done = -1;
        width_q.delete();
        waitc = 0;
        while (sl_at_done < 0 && waitc < 600) begin
            if (step && !prev) begin
                rises++;
                hi = 0;
            end
            if (step) hi++;
            if (!step && prev) width_q.push_back(hi);
            if (done) sl_at_done = int'(steps_left);
            prev = step;
            abort = (rises == 4 && hi == 4 && step) ? 1'b1 : 1'b0;
            @(negedge clk);
            waitc++;
        end
        abort = 1'b0;
        check("abort_rises", rises, 4);
        check("abort_widths", width_q.size(), 4);
        foreach (width_q[k]) check("abort_width", width_q[k], SW);
        check("abort_steps_left", sl_at_done, 6);
        check("abort_ready", cmd_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
